// File: rtl/seq_stim_tx.sv
// Serial stimulus transmitter: shifts a captured pattern out MSB-first, one bit per clock,
// for reps+1 passes with a one-cycle gap between passes, then pulses done.
module seq_stim_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cur_state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] idx_dec;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] rep_lim;

    assign idx_dec   = bit_idx - IDX_W'(1);
    assign cur_state = state;

    // Outputs are registered alongside the state they belong to, so each
    // transition loads the values the next cycle must show.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_idx    <= IDX_TOP;
            pass_cnt   <= '0;
            rep_lim    <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= SHIFT;
                        sr         <= pattern;
                        rep_lim    <= reps;
                        pass_cnt   <= '0;
                        bit_idx    <= IDX_TOP;
                        out_bit    <= pattern[WIDTH-1];
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state      <= IDLE;
                        out_bit    <= 1'b0;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end else if (bit_idx == '0) begin
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                        // Compare before incrementing so reps = all-ones never wraps.
                        if (pass_cnt == rep_lim) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= GAP;
                            pass_cnt <= pass_cnt + CNT_W'(1);
                        end
                    end else begin
                        bit_idx <= idx_dec;
                        out_bit <= sr[idx_dec];
                    end
                end
                GAP: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end else begin
                        state     <= SHIFT;
                        bit_idx   <= IDX_TOP;
                        out_bit   <= sr[WIDTH-1];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    out_bit    <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stim_tx.sv
// Bench for seq_stim_tx: a queue of expected per-cycle outputs built from each accepted load,
// compared every cycle, plus directed transactions with hand-computed literals.
module tb_seq_stim_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [6:0] IDLE_E = 7'b1000000;
    localparam logic [6:0] GAP_E  = 7'b0100010;
    localparam logic [6:0] DONE_E = 7'b0010011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] reps = '0;
    logic             load_ready, out_bit, out_valid, busy, done;
    logic [1:0]       cur_state;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp_now, act_now;
    logic       started = 1'b0;

    always #5 clk = ~clk;

    seq_stim_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .pattern(pattern), .reps(reps), .abort(abort), .out_bit(out_bit),
        .out_valid(out_valid), .busy(busy), .done(done), .cur_state(cur_state)
    );

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected-output queue: entry = {load_ready, busy, done, out_valid, out_bit, state}
    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (abort && (exp_q[0][1:0] == 2'b01 || exp_q[0][1:0] == 2'b10))
                exp_q.delete();
            else
                void'(exp_q.pop_front());
        end else if (load_valid) begin
            for (int p = 0; p <= int'(reps); p++) begin
                for (int b = WIDTH - 1; b >= 0; b--)
                    exp_q.push_back({4'b0101, pattern[b], 2'b01});
                if (p < int'(reps))
                    exp_q.push_back(GAP_E);
            end
            exp_q.push_back(DONE_E);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            exp_now = (exp_q.size() != 0) ? exp_q[0] : IDLE_E;
            act_now = {load_ready, busy, done, out_valid, out_bit, cur_state};
            n_checks++;
            if (act_now !== exp_now) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: got %b, expected %b", $time, act_now, exp_now);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (load_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1);
    endtask

    // Returns at the negedge of cycle 1 (first bit visible).
    task automatic start(input logic [7:0] p, input logic [3:0] r);
        pattern    = p;
        reps       = r;
        load_valid = 1'b1;
        for (int i = 0; i < 50 && load_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic capture(output logic [15:0] bits, output int done_cyc, output int busy_cyc,
                           input int intrude_at, input logic [7:0] intr_pat);
        bits     = '0;
        done_cyc = 0;
        busy_cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            if (c == intrude_at) begin
                load_valid = 1'b1;
                pattern    = intr_pat;
                reps       = '0;
            end
            if (out_valid === 1'b1) bits = {bits[14:0], out_bit};
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc == 0) chk("done_timeout", 0, 1);
    endtask

    logic [15:0] bits;
    int          dc, bc, seen;

    initial begin
        // Reset held with a load offered: nothing may be accepted.
        rst        = 1'b0;
        load_valid = 1'b1;
        pattern    = 8'h55;
        reps       = '0;
        repeat (2) @(negedge clk);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", cur_state, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_accept", out_valid, 1);
        chk("post_rst_first_bit", out_bit, 0);
        load_valid = 1'b0;
        wait_idle();

        start(8'hAA, 4'd0);
        capture(bits, dc, bc, 0, 8'h00);
        chk("single_bits", bits, 16'h00AA);
        chk("single_done_cycle", dc, 9);
        @(negedge clk);
        chk("single_ready_c10", load_ready, 1);

        start(8'hC3, 4'd1);
        capture(bits, dc, bc, 0, 8'h00);
        chk("gap_bits", bits, 16'hC3C3);
        chk("gap_done_cycle", dc, 18);
        chk("gap_busy_cycles", bc, 17);

        start(8'hFF, 4'd3);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", cur_state, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_ready", load_ready, 1);
        seen = 0;
        repeat (20) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);

        start(8'hAA, 4'd0);
        capture(bits, dc, bc, 3, 8'h0F);
        chk("busy_load_bits", bits, 16'h00AA);
        chk("busy_load_done", dc, 9);
        @(negedge clk);
        chk("busy_load_ready", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
        capture(bits, dc, bc, 0, 8'h00);
        chk("second_load_bits", bits, 16'h000F);
        chk("second_load_done", dc, 9);

        start(8'h81, 4'hF);
        capture(bits, dc, bc, 0, 8'h00);
        chk("maxrep_bits", bits, 16'h8181);
        chk("maxrep_done_cycle", dc, 144);
        chk("maxrep_busy_cycles", bc, 143);

        start(8'h81, 4'hF);
        repeat (39) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", cur_state, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_bit", out_bit, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", load_ready, 1);
        rst = 1'b1;
        wait_idle();

        // Random traffic: loads, aborts and resets at arbitrary points.
        repeat (2500) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) != 0);
            pattern    = WIDTH'($urandom);
            reps       = CNT_W'($urandom_range(0, 3));
            abort      = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst        = 1'b1;
        abort      = 1'b0;
        load_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
